// File: rtl/cam_ctrl_if.sv
// Request/response and CAM-side bundles for the CAM sequencing controller.
// The controller is the slave of cam_ctrl_if and the master of cam_ctrl_mem_if.
interface cam_ctrl_if #(
   parameter int DATA_WIDTH = 5,
   parameter int DATA_SIZE  = 1 << DATA_WIDTH
);
   logic                  req_valid;
   logic                  req_ready;
   logic [1:0]            req_op;
   logic [DATA_SIZE-1:0]  req_key;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_hit;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_index;
   logic [DATA_SIZE-1:0]  rsp_data;

   modport master (
      output req_valid, req_op, req_key, rsp_ready,
      input  req_ready, rsp_valid, rsp_hit, rsp_err,
      input  rsp_index, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_key, rsp_ready,
      output req_ready, rsp_valid, rsp_hit, rsp_err,
      output rsp_index, rsp_data
   );
endinterface

interface cam_ctrl_mem_if #(
   parameter int DATA_WIDTH = 5,
   parameter int DATA_SIZE  = 1 << DATA_WIDTH
);
   logic                  cam_write;
   logic                  cam_search;
   logic                  cam_read;
   logic [DATA_WIDTH-1:0] cam_write_index;
   logic [DATA_WIDTH-1:0] cam_read_index;
   logic [DATA_SIZE-1:0]  cam_write_data;
   logic [DATA_SIZE-1:0]  cam_search_data;
   logic [DATA_WIDTH-1:0] cam_search_index;
   logic                  cam_search_valid;
   logic [DATA_SIZE-1:0]  cam_read_value;
   logic                  cam_read_valid;

   modport master (
      output cam_write, cam_search, cam_read,
      output cam_write_index, cam_read_index,
      output cam_write_data, cam_search_data,
      input  cam_search_index, cam_search_valid,
      input  cam_read_value, cam_read_valid
   );

   modport slave (
      input  cam_write, cam_search, cam_read,
      input  cam_write_index, cam_read_index,
      input  cam_write_data, cam_search_data,
      output cam_search_index, cam_search_valid,
      output cam_read_value, cam_read_valid
   );
endinterface

// File: rtl/cam_ctrl.sv
// Sequencing controller for a single-port CAM: lookup/insert/delete/read.
// Define CAM_CTRL_OCC_EN to add the occ_count occupancy output.
module cam_ctrl #(
   parameter int                   DATA_WIDTH = 5,
   parameter int                   DATA_SIZE  = 1 << DATA_WIDTH,
   parameter logic [DATA_SIZE-1:0] TOMBSTONE  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef CAM_CTRL_OCC_EN
   output logic [DATA_WIDTH:0]   occ_count,
`endif
   cam_ctrl_if.slave             req,
   cam_ctrl_mem_if.master        cam
);

   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_INSERT = 2'b01;
   localparam logic [1:0] OP_DELETE = 2'b10;
   localparam logic [1:0] OP_READ   = 2'b11;
   localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(DATA_SIZE - 1);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_SEARCH, S_EVAL, S_READ, S_WRITE, S_RESP
   } state_t;

   state_t                r_state, w_state;
   logic [DATA_WIDTH-1:0] r_cnt, w_cnt;
   logic [DATA_SIZE-1:0]  r_map, w_map;
   logic [1:0]            r_op, w_op;
   logic [DATA_SIZE-1:0]  r_key, w_key;
   logic [DATA_WIDTH-1:0] r_idx, w_idx;
   logic                  r_rd_wait, w_rd_wait;

   logic                  r_req_ready, w_req_ready;
   logic                  r_rsp_valid, w_rsp_valid;
   logic                  r_rsp_hit, w_rsp_hit;
   logic                  r_rsp_err, w_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_index, w_rsp_index;
   logic [DATA_SIZE-1:0]  r_rsp_data, w_rsp_data;
   logic                  r_cam_write, w_cam_write;
   logic                  r_cam_search, w_cam_search;
   logic                  r_cam_read, w_cam_read;
   logic [DATA_WIDTH-1:0] r_wr_idx, w_wr_idx;
   logic [DATA_WIDTH-1:0] r_rd_idx, w_rd_idx;
   logic [DATA_SIZE-1:0]  r_wr_data, w_wr_data;
   logic [DATA_SIZE-1:0]  r_srch_data, w_srch_data;

   logic                  w_hit;
   logic                  w_full;
   logic [DATA_WIDTH-1:0] w_free;
   logic [DATA_WIDTH-1:0] w_sidx;

`ifdef CAM_CTRL_OCC_EN
   logic [DATA_WIDTH:0]   r_occ, w_occ;
   assign occ_count = r_occ;
`endif

   assign req.req_ready       = r_req_ready;
   assign req.rsp_valid       = r_rsp_valid;
   assign req.rsp_hit         = r_rsp_hit;
   assign req.rsp_err         = r_rsp_err;
   assign req.rsp_index       = r_rsp_index;
   assign req.rsp_data        = r_rsp_data;
   assign cam.cam_write       = r_cam_write;
   assign cam.cam_search      = r_cam_search;
   assign cam.cam_read        = r_cam_read;
   assign cam.cam_write_index = r_wr_idx;
   assign cam.cam_read_index  = r_rd_idx;
   assign cam.cam_write_data  = r_wr_data;
   assign cam.cam_search_data = r_srch_data;

   // A CAM match only counts when our own map says the slot is live.
   assign w_sidx = cam.cam_search_index;
   assign w_hit  = cam.cam_search_valid && r_map[w_sidx];
   assign w_full = &r_map;

   always_comb begin
      w_free = '0;
      for (int i = DATA_SIZE - 1; i >= 0; i--) begin
         if (!r_map[i]) w_free = DATA_WIDTH'(i);
      end
   end

   always_comb begin
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_map        = r_map;
      w_op         = r_op;
      w_key        = r_key;
      w_idx        = r_idx;
      w_rd_wait    = 1'b0;
      w_req_ready  = 1'b0;
      w_rsp_valid  = r_rsp_valid;
      w_rsp_hit    = r_rsp_hit;
      w_rsp_err    = r_rsp_err;
      w_rsp_index  = r_rsp_index;
      w_rsp_data   = r_rsp_data;
      w_cam_write  = 1'b0;
      w_cam_search = 1'b0;
      w_cam_read   = 1'b0;
      w_wr_idx     = '0;
      w_rd_idx     = '0;
      w_wr_data    = '0;
      w_srch_data  = '0;
`ifdef CAM_CTRL_OCC_EN
      w_occ        = r_occ;
`endif
      unique case (r_state)
         S_INIT: begin
            w_cam_write = 1'b1;
            w_wr_idx    = r_cnt;
            w_wr_data   = TOMBSTONE;
            w_cnt       = r_cnt + 1'b1;
            if (r_cnt == LAST_IDX) begin
               w_state     = S_IDLE;
               w_req_ready = 1'b1;
               w_cnt       = '0;
            end
         end
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (req.req_valid) begin
               w_req_ready = 1'b0;
               w_op        = req.req_op;
               w_key       = req.req_key;
               w_idx       = req.req_key[DATA_WIDTH-1:0];
               if (req.req_key == TOMBSTONE && req.req_op != OP_READ) begin
                  w_state     = S_RESP;
                  w_rsp_valid = 1'b1;
                  w_rsp_hit   = 1'b0;
                  w_rsp_err   = 1'b1;
                  w_rsp_index = '0;
                  w_rsp_data  = '0;
               end else if (req.req_op == OP_READ) begin
                  w_state    = S_READ;
                  w_cam_read = 1'b1;
                  w_rd_idx   = req.req_key[DATA_WIDTH-1:0];
               end else begin
                  w_state      = S_SEARCH;
                  w_cam_search = 1'b1;
                  w_srch_data  = req.req_key;
               end
            end
         end
         S_SEARCH: begin
            w_state = S_EVAL;
         end
         S_EVAL: begin
            w_state     = S_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_hit   = w_hit;
            w_rsp_err   = 1'b0;
            w_rsp_index = w_hit ? w_sidx : '0;
            w_rsp_data  = '0;
            unique case (r_op)
               OP_INSERT: begin
                  if (!w_hit && w_full) begin
                     w_rsp_err = 1'b1;
                  end else if (!w_hit) begin
                     w_state       = S_WRITE;
                     w_rsp_valid   = 1'b0;
                     w_rsp_index   = '0;
                     w_cam_write   = 1'b1;
                     w_wr_idx      = w_free;
                     w_wr_data     = r_key;
                     w_idx         = w_free;
                     w_map[w_free] = 1'b1;
`ifdef CAM_CTRL_OCC_EN
                     w_occ         = r_occ + 1'b1;
`endif
                  end
               end
               OP_DELETE: begin
                  if (w_hit) begin
                     w_state       = S_WRITE;
                     w_rsp_valid   = 1'b0;
                     w_rsp_hit     = 1'b0;
                     w_rsp_index   = '0;
                     w_cam_write   = 1'b1;
                     w_wr_idx      = w_sidx;
                     w_wr_data     = TOMBSTONE;
                     w_idx         = w_sidx;
                     w_map[w_sidx] = 1'b0;
`ifdef CAM_CTRL_OCC_EN
                     w_occ         = r_occ - 1'b1;
`endif
                  end
               end
               default: begin
               end
            endcase
         end
         S_WRITE: begin
            w_state     = S_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_hit   = (r_op == OP_DELETE);
            w_rsp_err   = 1'b0;
            w_rsp_index = r_idx;
            w_rsp_data  = '0;
         end
         S_READ: begin
            // First cycle only waits out the CAM read latency.
            if (!r_rd_wait) begin
               w_rd_wait = 1'b1;
            end else begin
               w_state     = S_RESP;
               w_rsp_valid = 1'b1;
               w_rsp_hit   = r_map[r_idx];
               w_rsp_err   = 1'b0;
               w_rsp_index = r_idx;
               w_rsp_data  = cam.cam_read_valid ? cam.cam_read_value : '0;
            end
         end
         S_RESP: begin
            if (req.rsp_ready) begin
               w_state     = S_IDLE;
               w_req_ready = 1'b1;
               w_rsp_valid = 1'b0;
               w_rsp_hit   = 1'b0;
               w_rsp_err   = 1'b0;
               w_rsp_index = '0;
               w_rsp_data  = '0;
            end
         end
         default: begin
            w_state = S_INIT;
            w_cnt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_INIT;
         r_cnt        <= '0;
         r_map        <= '0;
         r_op         <= '0;
         r_key        <= '0;
         r_idx        <= '0;
         r_rd_wait    <= 1'b0;
         r_req_ready  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_hit    <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_rsp_index  <= '0;
         r_rsp_data   <= '0;
         r_cam_write  <= 1'b0;
         r_cam_search <= 1'b0;
         r_cam_read   <= 1'b0;
         r_wr_idx     <= '0;
         r_rd_idx     <= '0;
         r_wr_data    <= '0;
         r_srch_data  <= '0;
`ifdef CAM_CTRL_OCC_EN
         r_occ        <= '0;
`endif
      end else begin
         r_state      <= w_state;
         r_cnt        <= w_cnt;
         r_map        <= w_map;
         r_op         <= w_op;
         r_key        <= w_key;
         r_idx        <= w_idx;
         r_rd_wait    <= w_rd_wait;
         r_req_ready  <= w_req_ready;
         r_rsp_valid  <= w_rsp_valid;
         r_rsp_hit    <= w_rsp_hit;
         r_rsp_err    <= w_rsp_err;
         r_rsp_index  <= w_rsp_index;
         r_rsp_data   <= w_rsp_data;
         r_cam_write  <= w_cam_write;
         r_cam_search <= w_cam_search;
         r_cam_read   <= w_cam_read;
         r_wr_idx     <= w_wr_idx;
         r_rd_idx     <= w_rd_idx;
         r_wr_data    <= w_wr_data;
         r_srch_data  <= w_srch_data;
`ifdef CAM_CTRL_OCC_EN
         r_occ        <= w_occ;
`endif
      end
   end

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural single-port CAM.
// Build with CAM_CTRL_OCC_EN defined to also check occ_count.
module tb_cam_ctrl;
   localparam int DW = 5;
   localparam int DS = 1 << DW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cam_ctrl_if     #(.DATA_WIDTH(DW)) req ();
   cam_ctrl_mem_if #(.DATA_WIDTH(DW)) cam ();

`ifdef CAM_CTRL_OCC_EN
   logic [DW:0] occ;
`endif

   cam_ctrl #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef CAM_CTRL_OCC_EN
      .occ_count (occ),
`endif
      .req       (req),
      .cam       (cam)
   );

   // Behavioural CAM: 1-cycle search/read latency, lowest index wins.
   logic [DS-1:0] mem [DS];
   initial for (int i = 0; i < DS; i++) mem[i] = DS'(i * 3 + 7);

   always @(posedge clk) begin
      if (cam.cam_write) mem[cam.cam_write_index] <= cam.cam_write_data;
      cam.cam_search_valid <= 1'b0;
      cam.cam_search_index <= '1;
      if (cam.cam_search) begin
         for (int i = DS - 1; i >= 0; i--) begin
            if (mem[i] == cam.cam_search_data) begin
               cam.cam_search_valid <= 1'b1;
               cam.cam_search_index <= DW'(i);
            end
         end
      end
      cam.cam_read_valid <= cam.cam_read;
      cam.cam_read_value <= cam.cam_read ? mem[cam.cam_read_index] : '0;
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic          g_hit, g_err;
   logic [DW-1:0] g_idx;
   logic [DS-1:0] g_data;
   int            g_lat, g_wr, g_srch, g_rd;
   logic [DW-1:0] g_wr_idx;
   logic [DS-1:0] g_wr_data;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [DS-1:0] key);
      int n;
      n = 0;
      while (!req.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req.req_ready) chk("req_ready_timeout", req.req_ready, 1);
      req.req_valid = 1'b1;
      req.req_op    = op;
      req.req_key   = key;
      @(negedge clk);
      req.req_valid = 1'b0;
      req.req_op    = '0;
      req.req_key   = '0;
      g_lat = 1; g_wr = 0; g_srch = 0; g_rd = 0;
      g_wr_idx = '0; g_wr_data = '0;
      while (!req.rsp_valid && g_lat < 20) begin
         if (cam.cam_write) begin
            g_wr++;
            g_wr_idx  = cam.cam_write_index;
            g_wr_data = cam.cam_write_data;
         end
         if (cam.cam_search) g_srch++;
         if (cam.cam_read) g_rd++;
         @(negedge clk);
         g_lat++;
      end
      if (!req.rsp_valid) chk("rsp_valid_timeout", req.rsp_valid, 1);
      g_hit  = req.rsp_hit;
      g_err  = req.rsp_err;
      g_idx  = req.rsp_index;
      g_data = req.rsp_data;
   endtask

   task automatic ack();
      req.rsp_ready = 1'b1;
      @(negedge clk);
      req.rsp_ready = 1'b0;
   endtask

   task automatic init_sweep();
      int cyc, nw;
      logic ok;
      cyc = 0; nw = 0; ok = 1'b1;
      rst = 1'b1;
      while (!req.req_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cam.cam_write) begin
            if (cam.cam_write_index != DW'(nw) || cam.cam_write_data != '0)
               ok = 1'b0;
            nw++;
         end
      end
      chk("init_ready_low_cycles", cyc, 32);
      chk("init_write_count", nw, 32);
      chk("init_write_seq", ok, 1);
      @(negedge clk);
      chk("init_write_done", cam.cam_write, 0);
   endtask

   initial begin
      req.req_valid = 1'b0;
      req.req_op    = '0;
      req.req_key   = '0;
      req.rsp_ready = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req.req_ready, 0);
      chk("rst_rsp_valid", req.rsp_valid, 0);
      chk("rst_cam_write", cam.cam_write, 0);
`ifdef CAM_CTRL_OCC_EN
      chk("rst_occ", occ, 0);
`endif
      init_sweep();

      send(2'b01, 7);
      chk("ins7_hit", g_hit, 0);
      chk("ins7_err", g_err, 0);
      chk("ins7_idx", g_idx, 0);
      chk("ins7_lat", g_lat, 4);
      chk("ins7_srch", g_srch, 1);
      chk("ins7_wr", g_wr, 1);
      chk("ins7_wr_data", g_wr_data, 7);
`ifdef CAM_CTRL_OCC_EN
      chk("ins7_occ", occ, 1);
`endif
      ack();

      send(2'b00, 7);
      chk("look7_hit", g_hit, 1);
      chk("look7_idx", g_idx, 0);
      chk("look7_lat", g_lat, 3);
      chk("look7_wr", g_wr, 0);
      ack();

      send(2'b11, 0);
      chk("rd0_data", g_data, 7);
      chk("rd0_hit", g_hit, 1);
      chk("rd0_idx", g_idx, 0);
      chk("rd0_strobe", g_rd, 1);
      ack();

      send(2'b01, 7);
      chk("reins7_hit", g_hit, 1);
      chk("reins7_idx", g_idx, 0);
      chk("reins7_wr", g_wr, 0);
      ack();

      send(2'b10, 7);
      chk("del7_hit", g_hit, 1);
      chk("del7_idx", g_idx, 0);
      chk("del7_lat", g_lat, 4);
      chk("del7_wr", g_wr, 1);
      chk("del7_wr_idx", g_wr_idx, 0);
      chk("del7_wr_data", g_wr_data, 0);
`ifdef CAM_CTRL_OCC_EN
      chk("del7_occ", occ, 0);
`endif
      ack();

      send(2'b00, 7);
      chk("look7_gone_hit", g_hit, 0);
      ack();

      for (int k = 1; k <= 32; k++) begin
         send(2'b01, DS'(k));
         chk("fill_idx", g_idx, k - 1);
         chk("fill_hit", g_hit, 0);
         ack();
      end
`ifdef CAM_CTRL_OCC_EN
      chk("full_occ", occ, 32);
`endif

      send(2'b01, 99);
      chk("full_err", g_err, 1);
      chk("full_hit", g_hit, 0);
      chk("full_idx", g_idx, 0);
      chk("full_wr", g_wr, 0);
      chk("full_lat", g_lat, 3);
      ack();

      send(2'b10, 5);
      chk("del5_hit", g_hit, 1);
      chk("del5_idx", g_idx, 4);
      ack();

      send(2'b01, 99);
      chk("ins99_idx", g_idx, 4);
      chk("ins99_err", g_err, 0);
      chk("ins99_hit", g_hit, 0);
`ifdef CAM_CTRL_OCC_EN
      chk("ins99_occ", occ, 32);
`endif
      ack();

      send(2'b00, 0);
      chk("tomb_err", g_err, 1);
      chk("tomb_lat", g_lat, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_rsp_valid", req.rsp_valid, 1);
         chk("hold_rsp_err", req.rsp_err, 1);
         chk("hold_req_ready", req.req_ready, 0);
         chk("hold_no_strobe",
             {cam.cam_search, cam.cam_write, cam.cam_read}, 0);
      end
      ack();

      send(2'b10, 10);
      chk("del10_idx", g_idx, 9);
      ack();

      // Abort an insert while it is in EVAL.
      req.req_valid = 1'b1;
      req.req_op    = 2'b01;
      req.req_key   = 77;
      @(negedge clk);
      req.req_valid = 1'b0;
      chk("abort_search", cam.cam_search, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_req_ready", req.req_ready, 0);
      chk("abort_rsp_valid", req.rsp_valid, 0);
      chk("abort_strobes",
          {cam.cam_search, cam.cam_write, cam.cam_read}, 0);
`ifdef CAM_CTRL_OCC_EN
      chk("abort_occ", occ, 0);
`endif
      repeat (3) @(negedge clk);
      chk("abort_no_rsp", req.rsp_valid, 0);
      init_sweep();

      send(2'b00, 1);
      chk("post_rst_look1", g_hit, 0);
      ack();
      send(2'b00, 77);
      chk("post_rst_look77", g_hit, 0);
      ack();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
